// File: rtl/tone_detector.sv
// tone_detector: square-wave tone classifier with hysteresis zero-crossing, half-period measurement and lock FSM.
// Optional stereo mixing of the tested sample is enabled by defining TONE_DETECTOR_STEREO_EN.
module tone_detector #(
    parameter logic signed [31:0] HYST       = 32'sd2000000,
    parameter int                 TOL        = 2100,
    parameter int                 MIN_STABLE = 3
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic [2:0]  note_code,
    output logic        note_valid,
    output logic [18:0] half_period
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam logic [18:0] CNT_MAX = 19'h7FFFF;
    localparam logic [6:0][18:0] NOM = {19'd101236, 19'd113637, 19'd127552, 19'd131927,
                                        19'd151516, 19'd170243, 19'd191132};
    localparam logic signed [32:0] HP = 33'(HYST);
    localparam logic signed [32:0] HN = -HP;

    state_t      state_q;
    logic        pol_q, pol_d;
    logic [18:0] cnt_q, cnt_d;
    logic [18:0] hp_q, hp_d;
    logic [2:0]  cand_q, code_q;
    logic [7:0]  match_q, match_nx;
    logic        valid_q;
    logic        flip, sat, lock_hit;
    logic [6:0]  hit;
    logic [2:0]  code;
    logic signed [32:0] samp;

`ifdef TONE_DETECTOR_STEREO_EN
    logic signed [32:0] sum;
    assign sum  = $signed({left_channel_audio_in[31], left_channel_audio_in})
                + $signed({right_channel_audio_in[31], right_channel_audio_in});
    assign samp = sum >>> 1;
`else
    logic unused_right;
    assign unused_right = ^right_channel_audio_in;
    assign samp = $signed({left_channel_audio_in[31], left_channel_audio_in});
`endif

    function automatic logic near(input logic [18:0] a, input logic [18:0] b);
        logic signed [31:0] d;
        d = $signed({13'd0, a}) - $signed({13'd0, b});
        return (d <= TOL) && (d >= -TOL);
    endfunction

    genvar g;
    for (g = 0; g < 7; g++) begin : g_hit
        assign hit[g] = near(cnt_q, NOM[g]);
    end

    assign code = hit[0] ? 3'd1 : hit[1] ? 3'd2 : hit[2] ? 3'd3 : hit[3] ? 3'd4 :
                  hit[4] ? 3'd5 : hit[5] ? 3'd6 : hit[6] ? 3'd7 : 3'd0;

    always_comb begin
        pol_d    = (audio_in_available && samp > HP) ? 1'b1 :
                   (audio_in_available && samp < HN) ? 1'b0 : pol_q;
        flip     = pol_d != pol_q;
        sat      = cnt_q == CNT_MAX;
        cnt_d    = flip ? 19'd0 : sat ? cnt_q : cnt_q + 19'd1;
        hp_d     = flip ? cnt_q : hp_q;
        match_nx = (code == cand_q) ? match_q + 8'd1 : 8'd1;
        lock_hit = {24'd0, match_nx} >= 32'(MIN_STABLE);
    end

    // Flip handling precedes the saturation timeout in every state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pol_q   <= 1'b0;
            cnt_q   <= '0;
            hp_q    <= '0;
            cand_q  <= '0;
            match_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
            cnt_q <= cnt_d;
            hp_q  <= hp_d;
            case (state_q)
                IDLE: begin
                    if (flip) begin
                        state_q <= TRACK;
                        cand_q  <= '0;
                        match_q <= '0;
                    end
                end
                TRACK: begin
                    if (flip) begin
                        if (code == 3'd0) begin
                            match_q <= '0;
                        end else begin
                            cand_q  <= code;
                            match_q <= match_nx;
                            if (lock_hit) begin
                                state_q <= LOCKED;
                                code_q  <= code;
                                valid_q <= 1'b1;
                            end
                        end
                    end else if (sat) begin
                        state_q <= IDLE;
                        match_q <= '0;
                        code_q  <= '0;
                        valid_q <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (flip) begin
                        if (code != code_q) begin
                            state_q <= TRACK;
                            valid_q <= 1'b0;
                            code_q  <= '0;
                            cand_q  <= code;
                            match_q <= (code != 3'd0) ? 8'd1 : 8'd0;
                        end
                    end else if (sat) begin
                        state_q <= IDLE;
                        match_q <= '0;
                        code_q  <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_audio_in = audio_in_available;
    assign note_code     = code_q;
    assign note_valid    = valid_q;
    assign half_period   = hp_q;
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: randomized square-wave stimulus checked against a streak-based reference model of tone_detector.
module tb_tone_detector;
    logic        clk = 1'b0, rst = 1'b0, avail = 1'b0;
    logic [31:0] left = '0, right = '0;
    logic        rd, valid;
    logic [2:0]  code;
    logic [18:0] hp;

    always #10 clk = ~clk;

    tone_detector dut (
        .CLOCK_50(clk), .reset(rst), .audio_in_available(avail),
        .left_channel_audio_in(left), .right_channel_audio_in(right),
        .read_audio_in(rd), .note_code(code), .note_valid(valid), .half_period(hp)
    );

    int checks = 0, failures = 0;
    int nom [7] = '{191132, 170243, 151516, 131927, 127552, 113637, 101236};
    int H = 151516, A = 10000000, t = 0, phase = 0, ticks = 0;
    int m_cnt, m_hp, m_code, m_len, m_flips = 0;
    bit m_pol, m_started, m_event, last_event;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int classify(input int p);
        int c = 0;
        for (int k = 0; k < 7; k++)
            if (p - nom[k] <= 2100 && nom[k] - p <= 2100) c = k + 1;
        return c;
    endfunction

    function automatic bit exp_valid();
        return m_started && m_len >= 3;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_hp = 0; m_pol = 0; m_started = 0; m_code = 0; m_len = 0;
    endtask

    // The model tracks the trailing run of identical nonzero codes since the last restart.
    task automatic tick();
        longint s, ts;
        int noise, c;
        bit np;
        avail = ((t + phase) % 1042) == 0;
        s = (((t / H) % 2) == 0) ? longint'(A) : -longint'(A);
        noise = int'($urandom_range(0, A / 5)) - A / 10;
        left = 32'(s + noise);
`ifdef TONE_DETECTOR_STEREO_EN
        right = 32'(s - noise);
        ts = (longint'($signed(left)) + longint'($signed(right))) >>> 1;
`else
        right = $urandom;
        ts = longint'($signed(left));
`endif
        np = m_pol;
        if (avail && ts > 2000000) np = 1;
        else if (avail && ts < -2000000) np = 0;
        m_event = 0;
        if (np != m_pol) begin
            m_flips++;
            m_event = 1;
            m_hp = m_cnt;
            if (!m_started) begin
                m_started = 1; m_len = 0; m_code = 0;
            end else begin
                c = classify(m_cnt);
                if (c != 0 && c == m_code) m_len++;
                else begin m_code = c; m_len = (c != 0) ? 1 : 0; end
            end
            m_cnt = 0;
        end else if (m_cnt == 524287) begin
            if (m_started) begin m_event = 1; m_started = 0; m_len = 0; m_code = 0; end
        end else m_cnt++;
        m_pol = np;
        @(posedge clk); #1;
        ticks++;
        if (m_event || last_event || ticks % 1000 == 0) begin
            check("note_valid", 32'(valid), 32'(exp_valid()));
            check("note_code", 32'(code), exp_valid() ? 32'(m_code) : 32'd0);
            check("half_period", 32'(hp), 32'(m_hp));
            check("read_audio_in", 32'(rd), 32'(avail));
        end
        last_event = m_event;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_flips(input int k, input int budget, input string tag);
        int target = m_flips + k;
        int n = 0;
        while (m_flips < target && n < budget) begin tick(); n++; end
        check(tag, 32'(m_flips >= target), 32'd1);
    endtask

    int hp_before;

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_code", 32'(code), 32'd0);
        check("reset_hp", 32'(hp), 32'd0);
        rst = 0;
        model_reset();

        phase = int'($urandom_range(0, 1041));
        H = 151516; A = 10000000; t = 0;
        run_flips(3, 600000, "a_flip3_timeout");
        check("a_nolock_at_flip3", 32'(valid), 32'd0);
        run_flips(1, 200000, "a_flip4_timeout");
        check("a_lock_valid", 32'(valid), 32'd1);
        check("a_lock_code", 32'(code), 32'd3);

        run(5000);
        #3 rst = 1;
        #1;
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_code", 32'(code), 32'd0);
        check("async_rst_hp", 32'(hp), 32'd0);
        model_reset();
        #1 rst = 0;

        run_flips(4, 800000, "b_relock_timeout");
        check("b_lock_valid", 32'(valid), 32'd1);
        check("b_lock_code", 32'(code), 32'd3);

        H = 113637;
        t = m_pol ? 0 : H;
        run_flips(1, 200000, "c_flip1_timeout");
        check("c_drop_valid", 32'(valid), 32'd0);
        check("c_drop_code", 32'(code), 32'd0);
        run_flips(1, 200000, "c_flip2_timeout");
        check("c_nolock_flip2", 32'(valid), 32'd0);
        run_flips(1, 200000, "c_flip3_timeout");
        check("c_relock_valid", 32'(valid), 32'd1);
        check("c_relock_code", 32'(code), 32'd6);

        A = 1000000;
        hp_before = m_hp;
        run(520000);
        check("d_still_locked", 32'(valid), 32'd1);
        check("d_flips_none", 32'(m_started), 32'd1);
        run(10000);
        check("d_timeout_valid", 32'(valid), 32'd0);
        check("d_timeout_code", 32'(code), 32'd0);
        check("d_hp_held", 32'(hp), 32'(hp_before));

        H = 140000; A = 10000000; t = 0;
        run_flips(5, 800000, "e_flips_timeout");
        check("e_hp_near", 32'((int'(hp) - 140000 <= 1042) && (140000 - int'(hp) <= 1042)), 32'd1);
        check("e_code", 32'(code), 32'd0);
        check("e_valid", 32'(valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_detector.md
TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 Parameter HYST, default 32'sd2000000, signed hysteresis threshold for polarity flips.
REQ-002 Parameter TOL, default 2100, allowed |half_period - nominal| in cycles for a match.
REQ-003 Parameter MIN_STABLE, default 3, consecutive same-code matches required for lock.
REQ-004 CLOCK_50  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 audio_in_available  in  1  controller holds at least one input sample.
REQ-007 left_channel_audio_in  in  32  signed left sample, valid while audio_in_available=1.
REQ-008 right_channel_audio_in  in  32  signed right sample; used only under REQ-030.
REQ-009 read_audio_in  out  1  pops one sample from the controller.
REQ-010 note_code  out  3  detected note, 0 = none, 1..7 = tone codes.
REQ-011 note_valid  out  1  note_code is locked.
REQ-012 half_period  out  19  last measured half-period in CLOCK_50 cycles.

Function
REQ-013 read_audio_in SHALL equal audio_in_available combinationally; the sample present in that cycle SHALL be consumed in that cycle.
REQ-014 Polarity register SHALL go positive when the consumed sample > +HYST and negative when < -HYST; otherwise it SHALL hold.
REQ-015 A flip is any cycle in which polarity changes.
REQ-016 Cycle counter SHALL increment every cycle, saturate at 19'h7FFFF, and clear to 0 on a flip.
REQ-017 On a flip, half_period SHALL latch the pre-clear counter value on the same edge.
REQ-018 Nominal half-periods: code 1..7 = 191132, 170243, 151516, 131927, 127552, 113637, 101236.
REQ-019 Classification SHALL yield the unique code within TOL of half_period, else 0; arithmetic SHALL use at least 20-bit signed differences.
REQ-020 FSM states: IDLE, TRACK, LOCKED; reset state IDLE.
REQ-021 IDLE: the first flip SHALL go to TRACK and SHALL NOT be classified, because that interval is partial.
REQ-022 TRACK: each flip SHALL be classified; a nonzero code equal to the candidate SHALL increment the match count; a different nonzero code SHALL become the candidate with count 1; code 0 SHALL clear the count.
REQ-023 TRACK to LOCKED when the match count reaches MIN_STABLE; on that edge note_code SHALL become the candidate and note_valid SHALL become 1.
REQ-024 LOCKED: a flip classifying to the locked code SHALL hold outputs; any other result SHALL drop note_valid and set note_code to 0 on the next edge, then go to TRACK with the candidate set to the new code (count 1, or 0 if the code is 0).
REQ-025 Timeout: counter saturated in TRACK or LOCKED SHALL go to IDLE with note_code=0, note_valid=0, and match count 0.
REQ-026 A flip and saturation in the same cycle: the flip SHALL take priority.
REQ-027 half_period SHALL hold between flips; it SHALL NOT be cleared on timeout.

Reset
REQ-028 On reset: note_code=0, note_valid=0, half_period=0, counter=0, polarity=negative, candidate and match count=0, state IDLE.
REQ-029 Reset asserted mid-lock SHALL force all of REQ-028 immediately, independent of CLOCK_50.

Configuration
REQ-030 With TONE_DETECTOR_STEREO_EN defined, the tested sample SHALL be (sign-extended left + right) arithmetically shifted right by 1 in 33-bit width.
REQ-031 Without TONE_DETECTOR_STEREO_EN, only left_channel_audio_in SHALL be tested and right_channel_audio_in SHALL be ignored.

Verification
REQ-032 Assert reset while LOCKED on code 3 -> note_code=0, note_valid=0, and half_period=0 before the next clock edge.
REQ-033 Square wave of ±10,000,000 with a 151516-cycle half-period, one sample per 1042 cycles -> note_valid=1 and note_code=3 after the 4th flip (one discarded flip, then 3 matches).
REQ-034 Same wave at ±1,000,000 amplitude -> no flips, note_valid stays 0, and timeout returns the FSM to IDLE.
REQ-035 Locked on code 3, then switch to a 113637-cycle half-period -> note_valid falls one edge after the first mismatching flip, and relocks to code 6 after 3 matching half-periods in total.
REQ-036 A 140000-cycle half-period -> half_period ≈ 140000 ±1042, note_code=0, and note_valid=0 throughout.
REQ-037 Locked on code 1, then samples held at 0 -> after 524287 cycles note_valid=0, note_code=0, state IDLE, and half_period unchanged.
